// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first, 8-bit frames) with a small register bus for firmware access.
// Optional feature macro SPI_TARGET_IRQ_EN adds an IRQ_MASK register and the o_irq output.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs,
    input  logic       i_sclk,
    input  logic       i_copi,
    output logic       o_cipo,
    output logic       o_cipo_oe,
`ifdef SPI_TARGET_IRQ_EN
    output logic       o_irq,
`endif
    input  logic       i_en,
    input  logic       i_wr,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    localparam logic [3:0] ADDR_RX     = 4'd0;
    localparam logic [3:0] ADDR_TX     = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
`ifdef SPI_TARGET_IRQ_EN
    localparam logic [3:0] ADDR_MASK   = 4'd3;
`endif

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic       cs_prev_q, cs_prev_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       rx_full_q, rx_full_d;
    logic       tx_full_q, tx_full_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic       reload_pend_q, reload_pend_d;
    logic       cipo_q, cipo_d;
    logic       cipo_oe_q, cipo_oe_d;
    logic [7:0] rdata_q, rdata_d;
`ifdef SPI_TARGET_IRQ_EN
    logic [3:0] mask_q, mask_d;
    logic       irq_q, irq_d;
`endif

    logic cs_s, sclk_s, copi_s;
    logic cs_active, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic reload, byte_done, bus_rd, bus_wr, rd_rx;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    always_comb begin
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        copi_sync_d   = {copi_sync_q[SYNC_STAGES-2:0], i_copi};
        cs_prev_d     = cs_s;
        sclk_prev_d   = sclk_s;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        tx_buf_d      = tx_buf_q;
        rx_full_d     = rx_full_q;
        tx_full_d     = tx_full_q;
        overrun_d     = overrun_q;
        underrun_d    = underrun_q;
        reload_pend_d = reload_pend_q;
        rdata_d       = rdata_q;
`ifdef SPI_TARGET_IRQ_EN
        mask_d        = mask_q;
        irq_d         = |(mask_q & {underrun_q, overrun_q, ~tx_full_q, rx_full_q});
`endif

        cs_active = ~cs_s;
        cs_fall   = cs_prev_q & ~cs_s;
        cs_rise   = ~cs_prev_q & cs_s;
        sclk_rise = cs_active & sclk_s & ~sclk_prev_q;
        sclk_fall = cs_active & ~sclk_s & sclk_prev_q;
        byte_done = sclk_rise & (bit_cnt_q == 3'd7);
        reload    = cs_fall | (sclk_fall & reload_pend_q);
        bus_rd    = i_en & ~i_wr;
        bus_wr    = i_en & i_wr;
        rd_rx     = bus_rd & (i_addr == ADDR_RX);

        // Flag clears come first so that a same-cycle set below wins.
        if (bus_wr && i_addr == ADDR_STATUS) begin
            if (i_data[2]) overrun_d  = 1'b0;
            if (i_data[3]) underrun_d = 1'b0;
        end
        if (rd_rx) rx_full_d = 1'b0;

        if (cs_rise || cs_fall) begin
            bit_cnt_d     = 3'd0;
            reload_pend_d = 1'b0;
        end
        if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], copi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
            rx_data_d     = {rx_shift_q[6:0], copi_s};
            rx_full_d     = 1'b1;
            reload_pend_d = 1'b1;
            if (rx_full_q && !rd_rx) overrun_d = 1'b1;
        end
        if (sclk_fall) begin
            tx_shift_d    = {tx_shift_q[6:0], 1'b0};
            reload_pend_d = 1'b0;
        end

        // Reload sees pre-write tx_full/tx_buf; a same-cycle TX write lands afterwards.
        if (reload) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end
        if (bus_wr && i_addr == ADDR_TX) begin
            tx_buf_d  = i_data;
            tx_full_d = 1'b1;
        end
`ifdef SPI_TARGET_IRQ_EN
        if (bus_wr && i_addr == ADDR_MASK) mask_d = i_data[3:0];
`endif

        if (bus_rd) begin
            case (i_addr)
                ADDR_RX:     rdata_d = rx_data_q;
                ADDR_STATUS: rdata_d = {3'b000, cs_active, underrun_q, overrun_q, tx_full_q, rx_full_q};
`ifdef SPI_TARGET_IRQ_EN
                ADDR_MASK:   rdata_d = {4'b0000, mask_q};
`endif
                default:     rdata_d = 8'h00;
            endcase
        end

        cipo_d    = cs_active ? tx_shift_d[7] : 1'b1;
        cipo_oe_d = cs_active;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cs_sync_q     <= '1;
            sclk_sync_q   <= '0;
            copi_sync_q   <= '0;
            cs_prev_q     <= 1'b1;
            sclk_prev_q   <= 1'b0;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            tx_shift_q    <= 8'h00;
            rx_data_q     <= 8'h00;
            tx_buf_q      <= 8'h00;
            rx_full_q     <= 1'b0;
            tx_full_q     <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
            reload_pend_q <= 1'b0;
            cipo_q        <= 1'b1;
            cipo_oe_q     <= 1'b0;
            rdata_q       <= 8'h00;
`ifdef SPI_TARGET_IRQ_EN
            mask_q        <= 4'h0;
            irq_q         <= 1'b0;
`endif
        end else begin
            cs_sync_q     <= cs_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            copi_sync_q   <= copi_sync_d;
            cs_prev_q     <= cs_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            tx_buf_q      <= tx_buf_d;
            rx_full_q     <= rx_full_d;
            tx_full_q     <= tx_full_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
            reload_pend_q <= reload_pend_d;
            cipo_q        <= cipo_d;
            cipo_oe_q     <= cipo_oe_d;
            rdata_q       <= rdata_d;
`ifdef SPI_TARGET_IRQ_EN
            mask_q        <= mask_d;
            irq_q         <= irq_d;
`endif
        end
    end

    assign o_cipo    = cipo_q;
    assign o_cipo_oe = cipo_oe_q;
    assign o_data    = rdata_q;
`ifdef SPI_TARGET_IRQ_EN
    assign o_irq     = irq_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: acts as the SPI controller (SCLK = clk/8) and as firmware on the bus.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       cipo;
    logic       cipo_oe;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
`ifdef SPI_TARGET_IRQ_EN
    logic       irq;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    spi_target dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cs      (cs),
        .i_sclk    (sclk),
        .i_copi    (copi),
        .o_cipo    (cipo),
        .o_cipo_oe (cipo_oe),
`ifdef SPI_TARGET_IRQ_EN
        .o_irq     (irq),
`endif
        .i_en      (en),
        .i_wr      (wr),
        .i_addr    (addr),
        .i_data    (wdata),
        .o_data    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = rdata;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Ends with SCLK still high after the last rise, so the frame closes without a trailing fall.
    task automatic cs_high();
        cs = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            copi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = cipo;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic xfer_byte(input string tag, input logic [7:0] tx);
        logic [7:0] rx;
        logic [7:0] exp;
        spi_bits(tx, 8, rx);
        exp = exp_q.pop_front();
        check_eq(tag, rx, exp);
    endtask

    initial begin
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check_eq("reset_cipo", {7'd0, cipo}, 8'h01);
        check_eq("reset_oe", {7'd0, cipo_oe}, 8'h00);
        check_eq("reset_odata", rdata, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reg("reset_status", 4'd2, 8'h00);
        check_reg("reserved_addr5", 4'd5, 8'h00);
`ifndef SPI_TARGET_IRQ_EN
        check_reg("reserved_addr3", 4'd3, 8'h00);
`endif

        // Basic exchange.
        reg_write(4'd1, 8'hA5);
        check_reg("tx_pending_status", 4'd2, 8'h02);
        cs_low();
        check_eq("oe_active", {7'd0, cipo_oe}, 8'h01);
        check_eq("cipo_first_bit", {7'd0, cipo}, 8'h01);
        exp_q.push_back(8'hA5);
        xfer_byte("xchg_ctrl_rx", 8'h3C);
        cs_high();
        check_eq("oe_idle", {7'd0, cipo_oe}, 8'h00);
        check_reg("xchg_status", 4'd2, 8'h01);
        check_reg("xchg_rx", 4'd0, 8'h3C);
        check_reg("xchg_status_after", 4'd2, 8'h00);

        // Underrun over a two-byte frame; first byte read back between bytes.
        cs_low();
        exp_q.push_back(8'hFF);
        xfer_byte("under_b0", 8'h11);
        check_reg("under_rx0", 4'd0, 8'h11);
        exp_q.push_back(8'hFF);
        xfer_byte("under_b1", 8'h22);
        cs_high();
        check_reg("under_status", 4'd2, 8'h09);
        check_reg("under_rx1", 4'd0, 8'h22);
        check_reg("under_status_rd", 4'd2, 8'h08);
        reg_write(4'd2, 8'h0C);
        check_reg("under_cleared", 4'd2, 8'h00);

        // Overrun: two bytes, no read in between; writes to a reserved address are ignored.
        reg_write(4'd7, 8'hFF);
        cs_low();
        exp_q.push_back(8'hFF);
        xfer_byte("over_b0", 8'h55);
        exp_q.push_back(8'hFF);
        xfer_byte("over_b1", 8'h66);
        cs_high();
        check_reg("over_status", 4'd2, 8'h0D);
        check_reg("over_rx", 4'd0, 8'h66);
        check_reg("over_status_rd", 4'd2, 8'h0C);
        reg_write(4'd2, 8'h04);
        check_reg("over_clear", 4'd2, 8'h08);
        reg_write(4'd2, 8'h0C);

        // Abort after five bits, then a clean byte.
        cs_low();
        check_reg("abort_status_cs", 4'd2, 8'h18);
        spi_bits(8'hF0, 5, d);
        cs_high();
        check_reg("abort_status", 4'd2, 8'h08);
        reg_write(4'd1, 8'h5A);
        cs_low();
        exp_q.push_back(8'h5A);
        xfer_byte("abort_next_tx", 8'h81);
        cs_high();
        check_reg("abort_next_status", 4'd2, 8'h09);
        check_reg("abort_next_rx", 4'd0, 8'h81);
        reg_write(4'd2, 8'h0C);
        check_eq("odata_hold", rdata, 8'h81);

`ifdef SPI_TARGET_IRQ_EN
        reg_write(4'd3, 8'h01);
        check_reg("irq_mask_rd", 4'd3, 8'h01);
        check_eq("irq_idle", {7'd0, irq}, 8'h00);
        cs_low();
        exp_q.push_back(8'hFF);
        xfer_byte("irq_ctrl_rx", 8'h7E);
        cs_high();
        check_eq("irq_set", {7'd0, irq}, 8'h01);
        check_reg("irq_rx", 4'd0, 8'h7E);
        repeat (2) @(negedge clk);
        check_eq("irq_clr", {7'd0, irq}, 8'h00);
`endif

        check_eq("exp_q_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
